// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared constants for the memory port arbiter
package arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_OWN  = 1'b1;

    localparam logic [SEL_W-1:0] REQ_FETCH = 2'd0;
    localparam logic [SEL_W-1:0] REQ_LDST  = 2'd1;
    localparam logic [SEL_W-1:0] REQ_DMA   = 2'd2;
    localparam logic [SEL_W-1:0] REQ_DEBUG = 2'd3;

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// rtl/mem_port_arbiter_rr_pick.sv - rotate-priority encoder starting at ptr
module rr_pick
    import arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic               valid,
    output logic [SEL_W-1:0]   idx
);

    logic [SEL_W-1:0] cand;

    // Scan from the farthest offset back to ptr so the nearest set bit wins
    always_comb begin
        valid = |req;
        idx   = '0;
        cand  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = ptr + SEL_W'(i);
            if (req[cand]) begin
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin owner arbiter for a shared memory port
module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int TMO_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               port_done,
    output logic [NUM_REQ-1:0] grant,
    output logic [SEL_W-1:0]   mux_sel,
    output logic               busy,
    output logic               timeout_err
);

    localparam logic [TMO_W-1:0] WD_LAST = TMO_W'(TIMEOUT - 1);

    logic [0:0]       state;
    logic [SEL_W-1:0] rr_ptr;
    logic [TMO_W-1:0] wd_cnt;
    logic             pick_valid;
    logic [SEL_W-1:0] pick_idx;
    logic             owner_req;
    logic             release_now;

    rr_pick u_rr_pick (
        .req   (req),
        .ptr   (rr_ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // Release evaluation for the current owner; done outranks withdraw outranks watchdog
    always_comb begin
        owner_req   = req[mux_sel];
        release_now = port_done || !owner_req || (wd_cnt == WD_LAST);
    end

    // Ownership FSM with round-robin pointer and watchdog
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            grant       <= '0;
            mux_sel     <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            rr_ptr      <= '0;
            wd_cnt      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    timeout_err <= 1'b0;
                    if (pick_valid) begin
                        grant   <= NUM_REQ'(1) << pick_idx;
                        mux_sel <= pick_idx;
                        busy    <= 1'b1;
                        wd_cnt  <= '0;
                        state   <= ST_OWN;
                    end
                end
                default: begin
                    if (release_now) begin
                        grant       <= '0;
                        busy        <= 1'b0;
                        rr_ptr      <= mux_sel + 1'b1;
                        state       <= ST_IDLE;
                        // Only a pure watchdog expiry reports an error
                        timeout_err <= !port_done && owner_req;
                    end else begin
                        wd_cnt      <= wd_cnt + 1'b1;
                        timeout_err <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic       port_done;
    logic [3:0] grant;
    logic [1:0] mux_sel;
    logic       busy;
    logic       timeout_err;

    int passed = 0;
    int total  = 0;

    mem_port_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .port_done   (port_done),
        .grant       (grant),
        .mux_sel     (mux_sel),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = 4'b1111; port_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if ({grant, mux_sel, busy, timeout_err} !== 8'b0)
                $display("FAIL reset_c%0d got g=%b s=%0d b=%b t=%b want all zero", i, grant, mux_sel, busy, timeout_err);
            else passed++;
        end
        req = 4'b0000;
        tick();
        rst_n = 1'b1;
        tick();
        total++;
        if (busy !== 1'b0) $display("FAIL idle_no_req got busy=%b want 0", busy);
        else passed++;
    endtask

    task automatic test_single();
        req = 4'b0100;
        tick();
        total++;
        if (grant !== 4'b0100 || mux_sel !== 2'd2 || busy !== 1'b1)
            $display("FAIL single_grant got g=%b s=%0d b=%b want 0100/2/1", grant, mux_sel, busy);
        else passed++;
        tick();
        tick();
        port_done = 1'b1; req = 4'b0000;
        tick();
        port_done = 1'b0;
        total++;
        if (grant !== 4'b0000 || busy !== 1'b0 || timeout_err !== 1'b0 || mux_sel !== 2'd2)
            $display("FAIL single_release got g=%b b=%b t=%b s=%0d want 0000/0/0/2", grant, busy, timeout_err, mux_sel);
        else passed++;
    endtask

    task automatic test_wrap();
        req = 4'b1001;
        tick();
        total++;
        if (grant !== 4'b1000 || mux_sel !== 2'd3)
            $display("FAIL wrap_first got g=%b s=%0d want 1000/3", grant, mux_sel);
        else passed++;
        port_done = 1'b1;
        tick();
        port_done = 1'b0;
        total++;
        if (grant !== 4'b0000 || mux_sel !== 2'd3)
            $display("FAIL wrap_idle got g=%b s=%0d want 0000/3", grant, mux_sel);
        else passed++;
        tick();
        total++;
        if (grant !== 4'b0001 || mux_sel !== 2'd0)
            $display("FAIL wrap_second got g=%b s=%0d want 0001/0", grant, mux_sel);
        else passed++;
        port_done = 1'b1; req = 4'b0000;
        tick();
        port_done = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            exp_g = 4'b0001 << (k % 4);
            total++;
            if (grant !== exp_g || mux_sel !== 2'(k % 4))
                $display("FAIL rr_grant_%0d got g=%b s=%0d want %b/%0d", k, grant, mux_sel, exp_g, k % 4);
            else passed++;
            tick();
            port_done = 1'b1;
            tick();
            port_done = 1'b0;
            total++;
            if (grant !== 4'b0000 || busy !== 1'b0)
                $display("FAIL rr_idle_%0d got g=%b b=%b want 0000/0", k, grant, busy);
            else passed++;
        end
        req = 4'b0000;
    endtask

    task automatic test_timeout();
        int early_bad;
        early_bad = 0;
        req = 4'b0010;
        tick();
        total++;
        if (grant !== 4'b0010) $display("FAIL tmo_grant got %b want 0010", grant);
        else passed++;
        for (int i = 0; i < 254; i++) begin
            tick();
            if (busy !== 1'b1 || timeout_err !== 1'b0 || grant !== 4'b0010) early_bad++;
        end
        total++;
        if (early_bad != 0) $display("FAIL tmo_hold got %0d bad cycles want 0", early_bad);
        else passed++;
        req = 4'b0110;
        tick();
        total++;
        if (grant !== 4'b0000 || timeout_err !== 1'b1)
            $display("FAIL tmo_expire got g=%b t=%b want 0000/1", grant, timeout_err);
        else passed++;
        tick();
        total++;
        if (timeout_err !== 1'b0 || grant !== 4'b0100)
            $display("FAIL tmo_after got t=%b g=%b want 0/0100", timeout_err, grant);
        else passed++;
        port_done = 1'b1; req = 4'b0000;
        tick();
        port_done = 1'b0;
    endtask

    task automatic test_abort();
        req = 4'b1000;
        tick();
        total++;
        if (grant !== 4'b1000) $display("FAIL abort_grant got %b want 1000", grant);
        else passed++;
        req = 4'b0000;
        tick();
        total++;
        if (grant !== 4'b0000 || busy !== 1'b0 || timeout_err !== 1'b0)
            $display("FAIL abort_release got g=%b b=%b t=%b want 0000/0/0", grant, busy, timeout_err);
        else passed++;
        tick();
        total++;
        if (timeout_err !== 1'b0) $display("FAIL abort_no_err got %b want 0", timeout_err);
        else passed++;
    endtask

    task automatic test_reset_mid();
        req = 4'b0100;
        tick();
        total++;
        if (grant !== 4'b0100) $display("FAIL rstmid_grant got %b want 0100", grant);
        else passed++;
        req = 4'b1111;
        tick();
        rst_n = 1'b0;
        tick();
        total++;
        if (grant !== 4'b0000 || busy !== 1'b0 || mux_sel !== 2'd0 || timeout_err !== 1'b0)
            $display("FAIL rstmid_clear got g=%b b=%b s=%0d t=%b want 0000/0/0/0", grant, busy, mux_sel, timeout_err);
        else passed++;
        rst_n = 1'b1;
        tick();
        total++;
        if (grant !== 4'b0001 || mux_sel !== 2'd0)
            $display("FAIL rstmid_ptr got g=%b s=%0d want 0001/0", grant, mux_sel);
        else passed++;
        req = 4'b0000;
        tick();
    endtask

    initial begin
        rst_n = 1'b0; req = 4'b0000; port_done = 1'b0;
        #2;
        test_reset();
        test_single();
        test_wrap();
        test_round_robin();
        test_timeout();
        test_abort();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
